mmio_interconnect: RTL and testbench
====================================

MMIO_INTERCONNECT -- requirements
Module: mmio_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8: number of word-spaced peripheral slots, range 1..32.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h10000000: slot 0 address; addresses below it are RAM.
REQ-003 SHALL have parameter DATA_W, default 32: data bus width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles to wait for an ack, range 1..255.
REQ-005 SHALL have ports as follows:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1 / 1  CPU request handshake.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response pulse.
- rsp_rdata  out  DATA_W  load data.
- rsp_err  out  1  error flag.
- ram_re / ram_we  out  1 / 1  RAM strobes.
- ram_rdata / ram_ack  in  DATA_W / 1  RAM return.
- periph_sel  out  NUM_SLOTS  one-hot slot select.
- periph_re / periph_we  out  1 / 1  peripheral strobes.
- periph_addr / periph_wdata  out  32 / DATA_W  broadcast address and data.
- periph_rdata  in  NUM_SLOTS*DATA_W  flattened, slot i at bits [i*DATA_W +: DATA_W].
- periph_ack  in  NUM_SLOTS  per-slot completion.

Function
REQ-006 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready SHALL be 1 only in IDLE.
REQ-007 SHALL register req_write, req_addr and req_wdata, and decode the target, on the cycle req_valid && req_ready.
REQ-008 SHALL decode as follows:
- addr < BASE_ADDR: RAM.
- BASE_ADDR <= addr < BASE_ADDR + 4*NUM_SLOTS with addr[1:0] == 0: slot (addr - BASE_ADDR) >> 2.
- Anything else, including a misaligned slot address: unmapped.
REQ-009 For an unmapped access, the FSM SHALL go IDLE -> RESP directly, with rsp_err = 1, rsp_rdata = 0, and no strobe issued.
REQ-010 On ACCESS entry, the FSM SHALL pulse exactly one strobe for exactly one cycle, chosen by target and req_write: ram_re, ram_we, periph_re or periph_we.
REQ-011 periph_sel, periph_addr and periph_wdata SHALL be held stable for all of ACCESS; periph_sel SHALL be 0 outside ACCESS.
REQ-012 In ACCESS, the FSM SHALL sample only the ack of the selected target, and ignore acks from unselected slots.
REQ-013 On an ack, including one in the same cycle as the strobe, the block SHALL capture the target's read data (loads) or 0 (stores) and go to RESP.
REQ-014 A wait counter SHALL count ACCESS cycles; if no ack arrives after TIMEOUT_CYCLES cycles, the FSM SHALL go to RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-015 An ack arriving on the final timeout cycle SHALL win over the timeout.
REQ-016 rsp_valid SHALL be high for exactly one cycle, in RESP; rsp_rdata and rsp_err SHALL be registered and hold their value until the next RESP.
REQ-017 Latency from the handshake cycle to rsp_valid SHALL be 2 cycles for an ack in the first ACCESS cycle, plus 1 per extra wait cycle; unmapped accesses SHALL take 1 cycle.
REQ-018 req_valid asserted outside IDLE SHALL be ignored; back-to-back requests SHALL be accepted starting from the IDLE cycle that follows RESP.

Reset
REQ-019 While rst_n = 0, the block SHALL be forced to IDLE with the wait counter at 0.
REQ-020 While rst_n = 0, all outputs SHALL be 0 except req_ready, which SHALL be 1.
REQ-021 Reset asserted mid-ACCESS SHALL abort the transfer with no rsp_valid; a late ack after reset SHALL be ignored.

Configuration
REQ-022 With MMIO_ERR_LOG_EN defined, the block SHALL add outputs err_count (16-bit, saturating at 16'hFFFF) and err_addr (32-bit, address of the last error), both cleared by reset and updated on the RESP cycle when rsp_err = 1.
REQ-023 Without MMIO_ERR_LOG_EN, neither port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-024 Package mmio_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP), the default BASE_ADDR, and the target-kind encoding (RAM, SLOT, UNMAPPED).
REQ-025 Combinational address decode SHALL live in sub-module mmio_slot_decode, with inputs address and outputs target kind, slot index and one-hot select.

Verification
REQ-026 A bench SHALL cover a load from 0x00000100 with ram_ack given in the strobe cycle and ram_rdata = 0xDEADBEEF -> rsp_valid 2 cycles after the handshake, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-027 A bench SHALL cover a store to 0x10000004 with 0x5A, acked after 3 wait cycles -> periph_sel = 8'b00000010, periph_we one cycle, periph_wdata = 0x5A, rsp_valid 5 cycles after the handshake.
REQ-028 A bench SHALL cover a load from 0x10000020 (NUM_SLOTS = 8) and a load from 0x10000006 -> no strobes, rsp_err = 1, rsp_rdata = 0, 1-cycle latency.
REQ-029 A bench SHALL cover a load from slot 2 that is never acked (TIMEOUT_CYCLES = 16) -> rsp_err = 1 exactly 17 cycles after the handshake; an ack on cycle 16 -> rsp_err = 0.
REQ-030 A bench SHALL cover periph_ack[5] pulsed while slot 3 is active -> ignored, and rst_n pulsed low mid-ACCESS -> no rsp_valid, outputs return to reset values.
REQ-031 A bench SHALL cover MMIO_ERR_LOG_EN with 3 unmapped accesses, the last to 0x20000000 -> err_count = 3, err_addr = 0x20000000.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg -- shared types and constants for the MMIO interconnect.
//   state_e    : FSM states IDLE / ACCESS / RESP
//   tgt_kind_e : decoded target kind RAM / SLOT / UNMAPPED
//   DEFAULT_BASE_ADDR : default address of peripheral slot 0
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RAM      = 2'd0,
        SLOT     = 2'd1,
        UNMAPPED = 2'd2
    } tgt_kind_e;

endpackage

// File: rtl/mmio_slot_decode.sv
// mmio_slot_decode -- combinational address decoder.
//   addr_i : byte address of the request
//   kind_o : RAM below BASE_ADDR, SLOT for an aligned address inside the
//            slot window, UNMAPPED otherwise
//   slot_o : slot index (valid when kind_o == SLOT)
//   sel_o  : one-hot slot select (all zero unless kind_o == SLOT)
module mmio_slot_decode
    import mmio_pkg::*;
#(
    parameter int          NUM_SLOTS = 8,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic [31:0]          addr_i,
    output tgt_kind_e            kind_o,
    output logic [4:0]           slot_o,
    output logic [NUM_SLOTS-1:0] sel_o
);

    logic [31:0] off;

    always_comb begin
        // Subtraction only matters when addr_i >= BASE_ADDR, so no wrap issue.
        off    = addr_i - BASE_ADDR;
        kind_o = UNMAPPED;
        slot_o = '0;
        sel_o  = '0;
        if (addr_i < BASE_ADDR) begin
            kind_o = RAM;
        end else if ((off < 32'(4 * NUM_SLOTS)) && (addr_i[1:0] == 2'b00)) begin
            kind_o = SLOT;
            slot_o = 5'(off >> 2);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                sel_o[i] = (5'(off >> 2) == 5'(i));
            end
        end
    end

endmodule

// File: rtl/mmio_interconnect.sv
// mmio_interconnect -- single-outstanding CPU to RAM / peripheral-slot bridge.
//   req_*    : CPU request (valid/ready; accepted only in IDLE)
//   rsp_*    : one-cycle response pulse with registered data / error flag
//   ram_*    : RAM strobes and return path
//   periph_* : one-hot slot select, broadcast address/data, per-slot returns
//   dbg_state: current FSM state
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so requests presented elsewhere are ignored.
// Optional feature: define MMIO_ERR_LOG_EN to add err_count / err_addr.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int          NUM_SLOTS      = 8,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int          DATA_W         = 32,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [31:0]                 req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        ram_re,
    output logic                        ram_we,
    input  logic [DATA_W-1:0]           ram_rdata,
    input  logic                        ram_ack,
    output logic [NUM_SLOTS-1:0]        periph_sel,
    output logic                        periph_re,
    output logic                        periph_we,
    output logic [31:0]                 periph_addr,
    output logic [DATA_W-1:0]           periph_wdata,
    input  logic [NUM_SLOTS*DATA_W-1:0] periph_rdata,
    input  logic [NUM_SLOTS-1:0]        periph_ack,
`ifdef MMIO_ERR_LOG_EN
    output logic [15:0]                 err_count,
    output logic [31:0]                 err_addr,
`endif
    output logic [1:0]                  dbg_state
);

    state_e                state_q;
    tgt_kind_e             kind_q;
    logic [4:0]            slot_q;
    logic                  write_q;
    logic [31:0]           addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [7:0]            wait_q;
    logic [NUM_SLOTS-1:0]  sel_q;
    logic                  ram_re_q, ram_we_q, periph_re_q, periph_we_q;
    logic                  rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0]     rsp_rdata_q;

    tgt_kind_e             dec_kind;
    logic [4:0]            dec_slot;
    logic [NUM_SLOTS-1:0]  dec_sel;

    mmio_slot_decode #(
        .NUM_SLOTS(NUM_SLOTS),
        .BASE_ADDR(BASE_ADDR)
    ) u_decode (
        .addr_i(req_addr),
        .kind_o(dec_kind),
        .slot_o(dec_slot),
        .sel_o (dec_sel)
    );

    // Ack and read data of the registered target only; other slots are ignored.
    logic              ack_hit;
    logic [DATA_W-1:0] rdata_hit;

    always_comb begin
        ack_hit   = 1'b0;
        rdata_hit = '0;
        if (kind_q == RAM) begin
            ack_hit   = ram_ack;
            rdata_hit = ram_rdata;
        end else if (kind_q == SLOT) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_q == 5'(i)) begin
                    ack_hit   = periph_ack[i];
                    rdata_hit = periph_rdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= RAM;
            slot_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            sel_q       <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            periph_re_q <= 1'b0;
            periph_we_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // Strobes and the response pulse are single-cycle by default.
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            periph_re_q <= 1'b0;
            periph_we_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        kind_q  <= dec_kind;
                        slot_q  <= dec_slot;
                        wait_q  <= '0;
                        if (dec_kind == UNMAPPED) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= ACCESS;
                            if (dec_kind == RAM) begin
                                ram_re_q <= !req_write;
                                ram_we_q <= req_write;
                            end else begin
                                periph_re_q <= !req_write;
                                periph_we_q <= req_write;
                                sel_q       <= dec_sel;
                            end
                        end
                    end
                end
                ACCESS: begin
                    // Ack is checked before the timeout so a last-cycle ack wins.
                    if (ack_hit) begin
                        state_q     <= RESP;
                        sel_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= write_q ? '0 : rdata_hit;
                    end else if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= RESP;
                        sel_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MMIO_ERR_LOG_EN
    logic [15:0] err_count_q;
    logic [31:0] err_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else if ((state_q == RESP) && rsp_err_q) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
            end
            err_addr_q <= addr_q;
        end
    end

    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;
`endif

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign ram_re       = ram_re_q;
    assign ram_we       = ram_we_q;
    assign periph_sel   = sel_q;
    assign periph_re    = periph_re_q;
    assign periph_we    = periph_we_q;
    assign periph_addr  = addr_q;
    assign periph_wdata = wdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// tb_mmio_interconnect -- directed scoreboard bench for mmio_interconnect.
// Define MMIO_ERR_LOG_EN for both bench and RTL to exercise the error log.
module tb_mmio_interconnect;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int TGT_NONE = -1;
    localparam int TGT_RAM  = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid, req_ready, req_write;
    logic [31:0]        req_addr;
    logic [DW-1:0]      req_wdata;
    logic               rsp_valid, rsp_err;
    logic [DW-1:0]      rsp_rdata;
    logic               ram_re, ram_we, ram_ack;
    logic [DW-1:0]      ram_rdata;
    logic [NS-1:0]      periph_sel, periph_ack;
    logic               periph_re, periph_we;
    logic [31:0]        periph_addr;
    logic [DW-1:0]      periph_wdata;
    logic [NS*DW-1:0]   periph_rdata;
    logic [1:0]         dbg_state;
`ifdef MMIO_ERR_LOG_EN
    logic [15:0]        err_count;
    logic [31:0]        err_addr;
`endif

    mmio_interconnect #(
        .NUM_SLOTS(NS), .BASE_ADDR(32'h1000_0000), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .periph_sel(periph_sel), .periph_re(periph_re), .periph_we(periph_we),
        .periph_addr(periph_addr), .periph_wdata(periph_wdata),
        .periph_rdata(periph_rdata), .periph_ack(periph_ack),
`ifdef MMIO_ERR_LOG_EN
        .err_count(err_count), .err_addr(err_addr),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: act=time-limit req=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    // {err, rdata, expected response cycle}
    logic [64:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: act=%0h req=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every rsp_valid must match the oldest expected response.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: act=rsp_valid req=none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e[63:32]));
                    check("rsp_err",   64'(rsp_err),   64'(e[64]));
                    check("rsp_cycle", 64'(cyc),       64'(e[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [3:0] strobes();
        return {ram_re, ram_we, periph_re, periph_we};
    endfunction

    task automatic wait_ready();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
        end
        if (k == 50) check("req_ready_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (k == 60) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // tgt: TGT_NONE (unmapped), TGT_RAM, or a slot index.
    // delay: ACCESS cycle (0-based) carrying the ack; -1 = never acked.
    // stray: slot acks pulsed in the first ACCESS cycle from unselected slots.
    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int tgt, input int delay, input logic [NS-1:0] stray,
                             input logic exp_err, input logic [31:0] exp_rdata, input int lat);
        int c, n;
        logic [3:0]    exp_strobe;
        logic [NS-1:0] one, exp_sel;
        one = 1;
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        c = cyc;
        exp_q.push_back({exp_err, exp_rdata, 32'(c + lat)});
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom_range(0, 32'h7FFF_FFFF);
        if (tgt == TGT_NONE)     exp_strobe = 4'b0000;
        else if (tgt == TGT_RAM) exp_strobe = wr ? 4'b0100 : 4'b1000;
        else                     exp_strobe = wr ? 4'b0001 : 4'b0010;
        exp_sel = (tgt >= 0 && tgt < TGT_RAM) ? (one << tgt) : '0;
        check("strobe_first", 64'(strobes()), 64'(exp_strobe));
        check("periph_sel",   64'(periph_sel), 64'(exp_sel));
        if (tgt >= 0 && tgt < TGT_RAM) begin
            check("periph_addr",  64'(periph_addr),  64'(addr));
            check("periph_wdata", 64'(periph_wdata), 64'(wdata));
        end
        if (tgt != TGT_NONE) begin
            n = (delay < 0) ? TO : delay + 1;
            for (int k = 0; k < n; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    check("strobe_once", 64'(strobes()), 64'd0);
                    check("sel_stable", 64'(periph_sel), 64'(exp_sel));
                end
                ram_ack    = (tgt == TGT_RAM) && (k == delay);
                periph_ack = ((tgt < TGT_RAM && k == delay) ? (one << tgt) : '0)
                           | ((k == 0) ? stray : '0);
            end
            @(negedge clk);
            ram_ack    = 1'b0;
            periph_ack = '0;
            check("sel_cleared", 64'(periph_sel), 64'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        ram_ack    = 1'b0;
        ram_rdata  = 32'hDEAD_BEEF;
        periph_ack = '0;
        for (int i = 0; i < NS; i++) periph_rdata[i*DW +: DW] = 32'hA000_0000 | 32'(i);

        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_outputs", 64'({rsp_valid, rsp_err, strobes(), periph_sel}), 64'd0);
        check("rst_data", 64'({rsp_rdata, periph_addr}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;

        // RAM load, ack in the strobe cycle
        do_access(1'b0, 32'h0000_0100, 32'h0, TGT_RAM, 0, '0, 1'b0, 32'hDEAD_BEEF, 2);
        // RAM store, one wait cycle
        do_access(1'b1, 32'h0000_0200, 32'h1234_5678, TGT_RAM, 1, '0, 1'b0, 32'h0, 3);
        // slot 1 store, acked after 3 wait cycles
        do_access(1'b1, 32'h1000_0004, 32'h0000_005A, 1, 3, '0, 1'b0, 32'h0, 5);
        // slot 3 load with a stray ack from slot 5
        do_access(1'b0, 32'h1000_000C, 32'h0, 3, 2, 8'b0010_0000, 1'b0, 32'hA000_0003, 4);
        // slot 7 load, back-to-back with the previous request
        do_access(1'b0, 32'h1000_001C, 32'h0, 7, 0, '0, 1'b0, 32'hA000_0007, 2);
        drain();

        // reset mid-ACCESS: aborted, no response, late ack ignored
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h1000_0004;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_outputs", 64'({rsp_valid, rsp_err, strobes(), periph_sel}), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        periph_ack = 8'b0000_0010;
        @(negedge clk);
        periph_ack = '0;
        repeat (3) @(negedge clk);
        check("post_rst_state", 64'(dbg_state), 64'd0);
        check("post_rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);

        // unmapped: just past the slot window, misaligned, far above
        do_access(1'b0, 32'h1000_0020, 32'h0, TGT_NONE, 0, '0, 1'b1, 32'h0, 1);
        do_access(1'b0, 32'h1000_0006, 32'h0, TGT_NONE, 0, '0, 1'b1, 32'h0, 1);
        do_access(1'b1, 32'h2000_0000, 32'h77, TGT_NONE, 0, '0, 1'b1, 32'h0, 1);
        drain();
        @(negedge clk);
`ifdef MMIO_ERR_LOG_EN
        check("err_count", 64'(err_count), 64'd3);
        check("err_addr",  64'(err_addr),  64'h2000_0000);
`endif

        // slot 2 timeout, then an ack on the final timeout cycle
        do_access(1'b0, 32'h1000_0008, 32'h0, 2, -1, '0, 1'b1, 32'h0, 17);
        do_access(1'b0, 32'h1000_0008, 32'h0, 2, 15, '0, 1'b0, 32'hA000_0002, 17);
        // a final mapped load after errors clears rsp_err
        do_access(1'b0, 32'h0000_0040, 32'h0, TGT_RAM, 0, '0, 1'b0, 32'hDEAD_BEEF, 2);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
